// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the lc3b EX stage.
// Picks the youngest matching producer (stages, then retired-write history) and tracks stall duration.
module fwd_hazard_unit #(
    parameter int NUM_STAGES = 3,
    parameter int HIST_DEPTH = 2,
    parameter int NUM_SRC    = 2,
    parameter int REG_W      = 3,
    parameter int DATA_W     = 16,
    parameter int SKIP_R0    = 1,
    parameter int MAX_STALL  = 15,
    parameter int SEL_W      = $clog2(NUM_STAGES + HIST_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pipe_advance,
    input  logic                         flush,
    input  logic [NUM_STAGES-1:0]        stage_valid,
    input  logic [NUM_STAGES*REG_W-1:0]  stage_dest,
    input  logic [NUM_STAGES-1:0]        stage_ready,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
    input  logic [NUM_SRC*REG_W-1:0]     src_idx,
    input  logic [NUM_SRC-1:0]           src_used,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0]    fwd_data,
    output logic                         hazard_stall,
    output logic                         stall_timeout,
    output logic [15:0]                  stall_count
);

    localparam int HD    = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
    localparam int RUN_W = $clog2(MAX_STALL + 1);

    typedef enum logic {RUN, STALL} state_t;

    logic [HD-1:0]     hist_valid;
    logic [REG_W-1:0]  hist_dest [HD];
    logic [DATA_W-1:0] hist_data [HD];

    logic [SEL_W-1:0]  pick_sel;
    logic [DATA_W-1:0] pick_data;
    logic              pick_pend;

    state_t            state, state_next;
    logic [RUN_W-1:0]  run_len, run_next;

    function automatic logic is_match(input logic v, input logic [REG_W-1:0] dest,
                                      input logic [REG_W-1:0] src);
        return v && (dest == src) && !((SKIP_R0 != 0) && (dest == '0));
    endfunction

    // Scan from lowest to highest priority so the last hit (the youngest producer) wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fwd_sel      = '0;
        fwd_data     = '0;
        hazard_stall = 1'b0;
        pick_sel     = '0;
        pick_data    = '0;
        pick_pend    = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            pick_sel  = '0;
            pick_data = '0;
            pick_pend = 1'b0;
            for (int h = HIST_DEPTH - 1; h >= 0; h--) begin
                if (is_match(hist_valid[h], hist_dest[h], src_idx[j*REG_W +: REG_W])) begin
                    pick_sel  = SEL_W'(NUM_STAGES + 1 + h);
                    pick_data = hist_data[h];
                    pick_pend = 1'b0;
                end
            end
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (is_match(stage_valid[k], stage_dest[k*REG_W +: REG_W],
                             src_idx[j*REG_W +: REG_W])) begin
                    pick_sel  = SEL_W'(k + 1);
                    pick_data = stage_data[k*DATA_W +: DATA_W];
                    pick_pend = !stage_ready[k];
                end
            end
            fwd_sel[j*SEL_W +: SEL_W]    = pick_sel;
            fwd_data[j*DATA_W +: DATA_W] = pick_data;
            hazard_stall                 = hazard_stall | (src_used[j] & pick_pend);
        end
    end

    generate
        if (HIST_DEPTH > 0) begin : g_hist
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hist_valid <= '0;
                end else if (pipe_advance) begin
                    // NOTE: non-blocking assignments make this a true shift: each entry reads its neighbour's old value.
                    for (int h = HD - 1; h > 0; h--) hist_valid[h] <= hist_valid[h-1];
                    hist_valid[0] <= stage_valid[NUM_STAGES-1];
                end
            end

            // NOTE: payload storage is not reset; the valid bits alone make stale entries invisible.
            always_ff @(posedge clk) begin
                if (pipe_advance) begin
                    for (int h = HD - 1; h > 0; h--) begin
                        hist_dest[h] <= hist_dest[h-1];
                        hist_data[h] <= hist_data[h-1];
                    end
                    hist_dest[0] <= stage_dest[(NUM_STAGES-1)*REG_W +: REG_W];
                    hist_data[0] <= stage_data[(NUM_STAGES-1)*DATA_W +: DATA_W];
                end
            end
        end else begin : g_no_hist
            always_comb begin
                hist_valid   = '0;
                hist_dest[0] = '0;
                hist_data[0] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_next = state;
        run_next   = run_len;
        if (flush) begin
            state_next = RUN;
            run_next   = '0;
        end else begin
            case (state)
                RUN: if (hazard_stall) begin
                    state_next = STALL;
                    run_next   = RUN_W'(1);
                end
                STALL: if (hazard_stall) begin
                    run_next = (run_len >= RUN_W'(MAX_STALL)) ? RUN_W'(MAX_STALL)
                                                              : run_len + RUN_W'(1);
                end else begin
                    state_next = RUN;
                    run_next   = '0;
                end
                default: begin
                    state_next = RUN;
                    run_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            run_len       <= '0;
            stall_timeout <= 1'b0;
            stall_count   <= '0;
        end else begin
            state   <= state_next;
            run_len <= run_next;
            if (run_next == RUN_W'(MAX_STALL)) stall_timeout <= 1'b1;
            if (hazard_stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic, all checked against
// a priority-search reference model with a queue-based history.
module tb_fwd_hazard_unit;

    localparam int NS   = 3;
    localparam int HD   = 2;
    localparam int NSRC = 2;
    localparam int RW   = 3;
    localparam int DW   = 16;
    localparam int SKR0 = 1;
    localparam int MAXS = 15;
    localparam int SW   = $clog2(NS + HD + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               pipe_advance;
    logic               flush;
    logic [NS-1:0]      stage_valid;
    logic [NS*RW-1:0]   stage_dest;
    logic [NS-1:0]      stage_ready;
    logic [NS*DW-1:0]   stage_data;
    logic [NSRC*RW-1:0] src_idx;
    logic [NSRC-1:0]    src_used;
    logic [NSRC*SW-1:0] fwd_sel;
    logic [NSRC*DW-1:0] fwd_data;
    logic               hazard_stall;
    logic               stall_timeout;
    logic [15:0]        stall_count;

    fwd_hazard_unit #(
        .NUM_STAGES(NS), .HIST_DEPTH(HD), .NUM_SRC(NSRC), .REG_W(RW),
        .DATA_W(DW), .SKIP_R0(SKR0), .MAX_STALL(MAXS), .SEL_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .pipe_advance(pipe_advance), .flush(flush),
        .stage_valid(stage_valid), .stage_dest(stage_dest), .stage_ready(stage_ready),
        .stage_data(stage_data), .src_idx(src_idx), .src_used(src_used),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .hazard_stall(hazard_stall),
        .stall_timeout(stall_timeout), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [RW-1:0] d;
        logic [DW-1:0] x;
    } hent_t;

    hent_t hist_q[$];
    int    m_run;
    bit    m_timeout;
    int    m_count;
    int    m_sel [NSRC];
    int    m_data[NSRC];
    bit    m_stall;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input bit v, input logic [RW-1:0] d, input logic [RW-1:0] s);
        return v && d == s && !(SKR0 != 0 && d == 0);
    endfunction

    task automatic model_reset();
        hist_q.delete();
        repeat (HD) hist_q.push_back('{v: 1'b0, d: '0, x: '0});
        m_run = 0; m_timeout = 0; m_count = 0;
    endtask

    // Walk producers youngest-first and stop at the first hit.
    task automatic model_eval();
        m_stall = 0;
        for (int j = 0; j < NSRC; j++) begin
            bit found = 0;
            bit pend  = 0;
            logic [RW-1:0] s = src_idx[j*RW +: RW];
            m_sel[j] = 0; m_data[j] = 0;
            for (int k = 0; k < NS && !found; k++)
                if (hit(stage_valid[k], stage_dest[k*RW +: RW], s)) begin
                    found = 1; m_sel[j] = k + 1;
                    m_data[j] = int'(stage_data[k*DW +: DW]);
                    pend = !stage_ready[k];
                end
            for (int h = 0; h < hist_q.size() && !found; h++)
                if (hit(hist_q[h].v, hist_q[h].d, s)) begin
                    found = 1; m_sel[j] = NS + 1 + h; m_data[j] = int'(hist_q[h].x);
                end
            if (src_used[j] && pend) m_stall = 1;
        end
    endtask

    task automatic model_edge();
        if (reset) return;
        if (m_stall && m_count < 65535) m_count++;
        if (flush) m_run = 0;
        else if (m_stall) m_run = (m_run + 1 > MAXS) ? MAXS : m_run + 1;
        else m_run = 0;
        if (!flush && m_run == MAXS) m_timeout = 1;
        if (pipe_advance) begin
            hist_q.push_front('{v: stage_valid[NS-1], d: stage_dest[(NS-1)*RW +: RW],
                                x: stage_data[(NS-1)*DW +: DW]});
            void'(hist_q.pop_back());
        end
    endtask

    task automatic compare_all();
        model_eval();
        for (int j = 0; j < NSRC; j++) begin
            check($sformatf("fwd_sel%0d", j), 32'(fwd_sel[j*SW +: SW]), 32'(m_sel[j]));
            check($sformatf("fwd_data%0d", j), 32'(fwd_data[j*DW +: DW]), 32'(m_data[j]));
        end
        check("hazard_stall", 32'(hazard_stall), 32'(m_stall));
        check("stall_count", 32'(stall_count), 32'(m_count));
        check("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next.
    task automatic tick();
        #2;
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        pipe_advance = 0; flush = 0;
        stage_valid = '0; stage_dest = '0; stage_ready = '1; stage_data = '0;
        src_idx = '0; src_used = '0;
    endtask

    task automatic set_stage(input int k, input bit v, input logic [RW-1:0] d,
                             input bit r, input logic [DW-1:0] x);
        stage_valid[k] = v; stage_dest[k*RW +: RW] = d;
        stage_ready[k] = r; stage_data[k*DW +: DW] = x;
    endtask

    task automatic set_src(input int j, input logic [RW-1:0] s, input bit u);
        src_idx[j*RW +: RW] = s; src_used[j] = u;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        model_reset();
        @(posedge clk); #1;
        tick();
        reset = 0;

        // Reset state with src = {R3, R2}
        set_src(0, 3'd2, 1); set_src(1, 3'd3, 1);
        #2;
        check("rst_sel", 32'(fwd_sel), 32'd0);
        check("rst_data", 32'(fwd_data), 32'd0);
        check("rst_stall", 32'(hazard_stall), 32'd0);
        check("rst_count", 32'(stall_count), 32'd0);
        tick();

        // Youngest of two matching stages wins
        set_stage(0, 1, 3'd2, 1, 16'h1111);
        set_stage(1, 1, 3'd2, 1, 16'h2222);
        #1;
        check("prio_sel0", 32'(fwd_sel[0 +: SW]), 32'd1);
        check("prio_data0", 32'(fwd_data[0 +: DW]), 32'h1111);
        tick();
        stage_valid[0] = 0;
        #1;
        check("older_sel0", 32'(fwd_sel[0 +: SW]), 32'd2);
        check("older_data0", 32'(fwd_data[0 +: DW]), 32'h2222);
        tick();

        // Younger stage not ready stalls even though the older one is ready
        set_stage(0, 1, 3'd2, 0, 16'h3333);
        #1;
        check("young_pend_stall", 32'(hazard_stall), 32'd1);
        tick();

        // Three-cycle load-use stall on operand 1
        clear_inputs();
        set_stage(0, 1, 3'd4, 0, 16'h4444);
        set_src(1, 3'd4, 1);
        for (int i = 0; i < 3; i++) begin
            #1; check("lu_stall", 32'(hazard_stall), 32'd1);
            tick();
        end
        stage_ready[0] = 1;
        #1; check("lu_release", 32'(hazard_stall), 32'd0);
        tick();
        check("lu_count", 32'(stall_count), 32'(1 + 3));
        check("lu_timeout", 32'(stall_timeout), 32'd0);

        // Retired write to R5 via history
        clear_inputs();
        set_stage(NS-1, 1, 3'd5, 1, 16'hBEEF);
        pipe_advance = 1;
        tick();
        clear_inputs();
        set_src(0, 3'd5, 1);
        #1;
        check("hist_sel0", 32'(fwd_sel[0 +: SW]), 32'(NS + 1));
        check("hist_data0", 32'(fwd_data[0 +: DW]), 32'hBEEF);
        tick();
        pipe_advance = 1;
        tick();
        #1; check("hist_old_sel0", 32'(fwd_sel[0 +: SW]), 32'(NS + 2));
        tick();
        #1; check("hist_drop_sel0", 32'(fwd_sel[0 +: SW]), 32'd0);
        tick();

        // R0 never matches
        clear_inputs();
        set_stage(0, 1, 3'd0, 0, 16'h5555);
        set_src(0, 3'd0, 1);
        #1;
        check("r0_sel", 32'(fwd_sel[0 +: SW]), 32'd0);
        check("r0_stall", 32'(hazard_stall), 32'd0);
        tick();

        // Timeout after MAX_STALL consecutive stalls, sticky afterwards
        clear_inputs();
        set_stage(1, 1, 3'd6, 0, 16'h6666);
        set_src(0, 3'd6, 1);
        for (int i = 1; i <= MAXS; i++) begin
            tick();
            check("to_flag", 32'(stall_timeout), 32'(i >= MAXS));
        end
        stage_ready[1] = 1;
        tick();
        check("to_sticky", 32'(stall_timeout), 32'd1);

        // Flush mid-stall keeps counting stalls but restarts the run
        stage_ready[1] = 0;
        tick(); flush = 1; tick(); flush = 0; tick();

        // Reset mid-stall takes effect without a clock edge
        stage_ready[1] = 0;
        tick(); tick();
        reset = 1;
        #2;
        check("arst_count", 32'(stall_count), 32'd0);
        check("arst_timeout", 32'(stall_timeout), 32'd0);
        model_reset();
        tick();
        reset = 0;

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < NS; k++)
                set_stage(k, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, 16'($urandom));
            for (int j = 0; j < NSRC; j++)
                set_src(j, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            pipe_advance = $urandom_range(0, 1);
            flush        = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised next-generation operand forwarding and hazard unit for the lc3b pipeline.
- Resolves each EX-stage source operand against N in-flight pipeline stages plus a HIST_DEPTH-deep history of retired writebacks, with priority given to the youngest producer.
- Detects load-use hazards, where the matching producer's data is not yet ready, and raises a stall.
- Tracks stall duration with a small FSM, a timeout flag and a saturating performance counter.
- Sits beside the EX stage and drives the ALU operand muxes and the pipeline stall logic.

Parameters:
- NUM_STAGES, 3, in-flight producer stages; index 0 is the youngest (EX/MEM), index NUM_STAGES-1 is WB.
- HIST_DEPTH, 2, retired-write history entries; 0 is legal and means no history.
- NUM_SRC, 2, source operands resolved per cycle.
- REG_W, 3, register index width.
- DATA_W, 16, data width.
- SKIP_R0, 1, when 1 a dest/src index of 0 never matches.
- MAX_STALL, 15, consecutive stall cycles that trigger a timeout.
- SEL_W, $clog2(NUM_STAGES+HIST_DEPTH+1), width of each select field.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pipe_advance  in  1  pipeline moves this cycle; history shifts only when this is 1
- flush  in  1  synchronous clear of the stall FSM and stall run length
- stage_valid  in  NUM_STAGES  stage k writes the regfile (load_regfile)
- stage_dest  in  NUM_STAGES*REG_W  destination register of stage k
- stage_ready  in  NUM_STAGES  stage k result is available this cycle
- stage_data  in  NUM_STAGES*DATA_W  result of stage k
- src_idx  in  NUM_SRC*REG_W  source register index of operand j
- src_used  in  NUM_SRC  operand j is actually read by the instruction in EX
- fwd_sel  out  NUM_SRC*SEL_W  0 = regfile, 1..NUM_STAGES = stage k+1, NUM_STAGES+1.. = history entry h+NUM_STAGES+1
- fwd_data  out  NUM_SRC*DATA_W  selected forwarded value; 0 when fwd_sel is 0
- hazard_stall  out  1  a used operand's selected producer is not ready
- stall_timeout  out  1  sticky; set when MAX_STALL is reached
- stall_count  out  16  saturating count of total stall cycles

Behaviour:

Reset (asynchronous):
- All history valid bits = 0; FSM = RUN.
- Stall run length = 0; stall_timeout = 0; stall_count = 0.
- Combinational outputs follow from these: with no stage inputs valid, fwd_sel = 0, fwd_data = 0 and hazard_stall = 0.

Match rule:
- Stage k matches operand j when stage_valid[k], dest == src_idx[j], and !(SKIP_R0 && dest == 0).
- History entry h matches under the same rule using its stored valid and dest.

Priority:
- Stage 0 has the highest priority, then increasing k, then history h = 0 (most recent) upward.
- Only the highest-priority match is selected; older matches are ignored even when ready.
- fwd_sel, fwd_data and hazard_stall are combinational with zero-cycle latency.

Hazard:
- hazard_stall = OR over j of (src_used[j] && the selected producer is a stage && !stage_ready[selected]).
- History entries are always ready.
- An unused operand never stalls, but fwd_sel is still computed for it.

History:
- On a clk edge with pipe_advance = 1, entries shift (h to h+1, the oldest is dropped).
- Entry 0 loads {stage_valid, stage_dest, stage_data} of stage NUM_STAGES-1.
- When pipe_advance = 0, history holds.
- Entries are retired writes and are NOT cleared by flush.

Stall FSM (states RUN and STALL):
- RUN to STALL when hazard_stall = 1; the run length is loaded with 1.
- STALL stays in STALL while hazard_stall = 1; the run length increments and saturates at MAX_STALL.
- STALL returns to RUN when hazard_stall = 0; the run length clears to 0.
- When the run length reaches MAX_STALL, stall_timeout is set and held until reset.
- stall_count increments every cycle in which hazard_stall = 1, saturating at 0xFFFF.
- flush has priority: it forces RUN and clears the run length the next cycle. It does not touch stall_count or stall_timeout.
- The FSM is bookkeeping only; it never gates hazard_stall.

Boundary conditions:
- Two stages with the same dest: the younger wins, including when it is not ready. This stalls even if the older stage is ready.
- Both operands hazard: a single stall per cycle, counted once.
- Reset asserted mid-stall: the FSM returns to RUN asynchronously and the counters clear.

Test Plan:
- Reset, then src_idx = {R2, R3}, no stage valid -> fwd_sel = {0, 0}, fwd_data = 0, hazard_stall = 0, stall_count = 0.
- Stage0 dest R2 ready data 0x1111; stage1 dest R2 ready 0x2222; src0 = R2 -> fwd_sel0 = 1, fwd_data0 = 0x1111. Clear stage0 valid -> fwd_sel0 = 2, fwd_data0 = 0x2222.
- Stage0 dest R4 not ready, src1 = R4 used, for 3 cycles, then ready -> hazard_stall = 1 for exactly 3 cycles, stall_count = 3, FSM back in RUN, stall_timeout = 0.
- WB stage writes R5 = 0xBEEF with pipe_advance = 1; the next cycle no stage is valid and src0 = R5 -> fwd_sel0 = NUM_STAGES+1 (4), fwd_data0 = 0xBEEF. Two more advances -> the entry is dropped and fwd_sel0 = 0.
- SKIP_R0 = 1 with stage0 dest R0 not ready and src0 = R0 -> fwd_sel0 = 0, hazard_stall = 0.
- Hold the hazard for 15 cycles -> stall_timeout rises in cycle 15 and stays 1 after the hazard clears. Then assert reset mid-stall -> all state returns to reset values immediately, without waiting for clk.
